// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_mem_pkg
// Description : Shared types and default widths for the data-memory path.
//               Arbiter FSM states, read-return owner encoding and default
//               address/data/starvation parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    localparam int C_ADDR_W   = 32;
    localparam int C_DATA_W   = 32;
    localparam int C_MAX_WAIT = 4;

    typedef enum logic [0:0] {
        ARB     = 1'b0,
        LOCKED1 = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter in front of a single-port synchronous data
//               memory. Port 0 (core) has fixed priority, port 1 (loader)
//               wins after MAX_WAIT stalled cycles and may lock the memory
//               for an exclusive burst. Read data returns one cycle after
//               acceptance and is routed only to the port that issued it.
// Ports       : clk, reset (sync, active-low)
//               p0_* / p1_* : requester ports (valid/we/addr/wdata/wmask in,
//                             ready/rvalid/rdata out), p0_stall, p1_lock
//               mem_*       : memory strobe, write enable, address, data,
//                             byte mask out; mem_rdata in
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W   = C_ADDR_W,
    parameter int DATA_W   = C_DATA_W,
    parameter int MAX_WAIT = C_MAX_WAIT
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                p0_valid,
    input  logic                p0_we,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    output logic                p0_ready,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    output logic                p0_stall,

    input  logic                p1_valid,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    input  logic                p1_lock,
    output logic                p1_ready,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] C_WAIT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    owner_t           r_rd_owner;
    owner_t           w_rd_owner_nxt;
    logic             w_grant0;
    logic             w_grant1;

    // ------------------------------------------------------------------
    // Grant and next-state logic. Grants are forced low while reset is
    // asserted so nothing reaches the memory during reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_state_nxt = r_state;
        if (reset) begin
            case (r_state)
                ARB: begin
                    w_grant1 = p1_valid & (~p0_valid | (r_wait_cnt == C_WAIT_MAX));
                    w_grant0 = p0_valid & ~w_grant1;
                    if (w_grant1 && p1_lock) begin
                        w_state_nxt = LOCKED1;
                    end
                end
                LOCKED1: begin
                    // Port 0 stays blocked during the release cycle too.
                    w_grant1 = p1_valid;
                    if (!p1_lock) begin
                        w_state_nxt = ARB;
                    end
                end
                default: w_state_nxt = ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive stalled port-1 cycles and
    // saturates, so port 1 wins exactly once when it reaches MAX_WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (p1_valid && !w_grant1) begin
            if (r_wait_cnt != C_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Read-return ownership: remembers which port issued the read that the
    // memory answers in the next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_grant0 && !p0_we) begin
            w_rd_owner_nxt = OWN_P0;
        end else if (w_grant1 && !p1_we) begin
            w_rd_owner_nxt = OWN_P1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side mux; all fields are zero when no port is granted.
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (w_grant0) begin
            mem_en    = 1'b1;
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wmask = p0_wmask;
        end else if (w_grant1) begin
            mem_en    = 1'b1;
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wmask = p1_wmask;
        end
    end

    assign p0_ready = w_grant0;
    assign p1_ready = w_grant1;
    assign p0_stall = p0_valid & ~w_grant0;

    // Gating with reset suppresses the return of a read accepted just
    // before reset asserts.
    assign p0_rvalid = reset & (r_rd_owner == OWN_P0);
    assign p1_rvalid = reset & (r_rd_owner == OWN_P1);
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural
//               single-port memory and a per-port read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_valid = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [3:0]  p0_wmask = '0;
    logic        p0_ready, p0_rvalid, p0_stall;
    logic [31:0] p0_rdata;
    logic        p1_valid = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p1_wmask = '0;
    logic        p1_ready, p1_rvalid;
    logic [31:0] p1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_wmask(p0_wmask), .p0_ready(p0_ready),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_lock(p1_lock),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory, read latency one cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                logic [31:0] old;
                old = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) old[b*8 +: 8] = mem_wdata[b*8 +: 8];
                mem_arr[mem_addr] = old;
            end else begin
                mem_rdata <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
            end
        end
    end

    // Read-return monitor: rvalid must pulse exactly when a scoreboard entry
    // falls due on that port, and the non-owner must read back zero.
    always @(negedge clk) begin
        checks++;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            if (p0_rvalid !== 1'b1 || p0_rdata !== q0[0].data) begin
                errors++;
                $display("FAIL p0_return cyc=%0d got rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                         cyc, p0_rvalid, p0_rdata, q0[0].data);
            end
            void'(q0.pop_front());
        end else if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL p0_spurious cyc=%0d got rvalid=%b rdata=%h exp rvalid=0 rdata=0",
                     cyc, p0_rvalid, p0_rdata);
        end
        checks++;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            if (p1_rvalid !== 1'b1 || p1_rdata !== q1[0].data) begin
                errors++;
                $display("FAIL p1_return cyc=%0d got rvalid=%b rdata=%h exp rvalid=1 rdata=%h",
                         cyc, p1_rvalid, p1_rdata, q1[0].data);
            end
            void'(q1.pop_front());
        end else if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL p1_spurious cyc=%0d got rvalid=%b rdata=%h exp rvalid=0 rdata=0",
                     cyc, p1_rvalid, p1_rdata);
        end
    end

    task automatic drive0(input logic v, input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = wd; p0_wmask = 4'hF;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic lk);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = wd; p1_wmask = 4'hF;
        p1_lock = lk;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    // Update the reference memory / scoreboard for whatever was accepted.
    task automatic note_accept();
        exp_t e;
        if (p0_ready) begin
            if (p0_we) model_mem[p0_addr] = p0_wdata;
            else begin
                e.data = model_read(p0_addr); e.due = cyc + 1; q0.push_back(e);
            end
        end
        if (p1_ready) begin
            if (p1_we) model_mem[p1_addr] = p1_wdata;
            else begin
                e.data = model_read(p1_addr); e.due = cyc + 1; q1.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive0(0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
            #1 note_accept();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive0(1, 0, 32'h0, 0); drive1(0, 0, 0, 0, 0);
            #1;
            checks++;
            if (p0_ready !== 1'b0 || mem_en !== 1'b0 || p0_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got ready0=%b mem_en=%b rvalid0=%b exp 0 0 0",
                         p0_ready, mem_en, p0_rvalid);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got ready0=%b exp 1", p0_ready);
        end
        note_accept();
        idle(2);
    endtask

    task automatic test_core_only();
        @(negedge clk);
        drive0(1, 1, 32'h10, 32'hDEADBEEF);
        #1;
        checks++;
        if (p0_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
            mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || mem_wmask !== 4'hF) begin
            errors++;
            $display("FAIL core_store got ready=%b en=%b we=%b addr=%h wd=%h m=%h exp 1 1 1 10 deadbeef f",
                     p0_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask);
        end
        note_accept();
        @(negedge clk);
        drive0(1, 0, 32'h10, 0);
        #1;
        checks++;
        if (p0_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL core_load got ready=%b we=%b exp 1 0", p0_ready, mem_we);
        end
        note_accept();
        idle(2);
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 10; k++) begin
            logic exp1;
            @(negedge clk);
            drive0(1, 0, 32'h10, 0); drive1(1, 0, 32'h100, 0, 0);
            #1;
            exp1 = (k % 5 == 4);
            checks++;
            if (p1_ready !== exp1 || p0_ready !== !exp1 || p0_stall !== exp1) begin
                errors++;
                $display("FAIL starve k=%0d got r1=%b r0=%b stall0=%b exp r1=%b r0=%b stall0=%b",
                         k, p1_ready, p0_ready, p0_stall, exp1, !exp1, exp1);
            end
            note_accept();
        end
        idle(2);
    endtask

    task automatic test_lock_burst();
        int waits = 0;
        logic got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            drive0(1, 0, 32'h10, 0); drive1(1, 1, 32'h100, 32'd0, 1);
            #1;
            if (p1_ready) got = 1'b1; else waits++;
            note_accept();
        end
        checks++;
        if (!got || waits != 4) begin
            errors++;
            $display("FAIL lock_first_grant got granted=%b waits=%0d exp granted=1 waits=4", got, waits);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            drive1(1, 1, 32'h100 + 32'(4 * i), 32'(i), 1);
            #1;
            checks++;
            if (p1_ready !== 1'b1 || p0_stall !== 1'b1 || p0_ready !== 1'b0) begin
                errors++;
                $display("FAIL lock_beat i=%0d got r1=%b stall0=%b r0=%b exp 1 1 0",
                         i, p1_ready, p0_stall, p0_ready);
            end
            note_accept();
        end
        @(negedge clk);
        drive1(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (p0_ready !== 1'b0 || p0_stall !== 1'b1) begin
            errors++;
            $display("FAIL lock_release got r0=%b stall0=%b exp 0 1", p0_ready, p0_stall);
        end
        note_accept();
        @(negedge clk);
        drive0(1, 0, 32'h104, 0);
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_after got r0=%b exp 1", p0_ready);
        end
        note_accept();
        idle(2);
    endtask

    task automatic test_read_ownership();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                drive0(1, 0, 32'h10, 0); drive1(0, 0, 0, 0, 0);
            end else begin
                drive0(0, 0, 0, 0); drive1(1, 0, 32'h100 + 32'(4 * k), 0, 0);
            end
            #1;
            checks++;
            if (p0_ready !== (k % 2 == 0) || p1_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL own_grant k=%0d got r0=%b r1=%b", k, p0_ready, p1_ready);
            end
            note_accept();
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        // Reset must return the FSM to ARB.
        @(negedge clk);
        drive1(1, 1, 32'h120, 32'hA5A5_5A5A, 1);
        #1;
        checks++;
        if (p1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_lock_grant got r1=%b exp 1", p1_ready);
        end
        note_accept();
        @(negedge clk);
        reset = 1'b0;
        drive1(0, 0, 0, 0, 1);
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_en got %b exp 0", mem_en);
        end
        @(negedge clk);
        reset = 1'b1;
        drive0(1, 0, 32'h120, 0);
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_state_arb got r0=%b exp 1", p0_ready);
        end
        note_accept();
        // Build up wait_cnt, then reset right after a port-0 read.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive0(1, 0, 32'h10, 0); drive1(1, 0, 32'h100, 0, 0);
            #1;
            checks++;
            if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_pre k=%0d got r0=%b r1=%b exp 1 0", k, p0_ready, p1_ready);
            end
            if (k < 2) note_accept();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rvalid got %b exp 0", p0_rvalid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            reset = 1'b1;
            drive0(1, 0, 32'h10, 0); drive1(1, 0, 32'h100, 0, 0);
            #1;
            checks++;
            if (p1_ready !== (k == 4)) begin
                errors++;
                $display("FAIL rst_cnt_clear k=%0d got r1=%b exp %b", k, p1_ready, (k == 4));
            end
            note_accept();
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_core_only();
        test_starvation();
        test_lock_burst();
        test_read_ownership();
        test_reset_mid_read();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: port 0 = core load/store unit, port 1 = program/data loader (bench or debug).
- Sits inside top, between the core's data-memory interface and the dmem instance.
- One access per cycle, fixed priority to the core with a starvation guard for the loader.
- The loader can lock the memory for an exclusive burst.

Parameters:
- ADDR_W, 32, address width on both ports and on the memory side.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- MAX_WAIT, 4, consecutive stalled cycles after which port 1 beats port 0; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- p0_valid  in  1  core request.
- p0_we  in  1  1 = store, 0 = load.
- p0_addr  in  ADDR_W  byte address.
- p0_wdata  in  DATA_W  store data.
- p0_wmask  in  DATA_W/8  byte enables.
- p0_ready  out  1  request accepted this cycle.
- p0_rvalid  out  1  load data valid.
- p0_rdata  out  DATA_W  load data.
- p0_stall  out  1  p0_valid & ~p0_ready; freezes the core PC.
- p1_valid, p1_we, p1_addr, p1_wdata, p1_wmask, p1_ready, p1_rvalid, p1_rdata: same as p0.
- p1_lock  in  1  hold the grant for port 1 while high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  DATA_W/8  byte enables.
- mem_rdata  in  DATA_W  read data, valid one cycle after a read strobe.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state = ARB, wait_cnt = 0, rd_owner = none.
  - p0_rvalid = p1_rvalid = 0.
  - While reset is low, ready0/ready1/mem_en are forced to 0.
  - A read accepted in the cycle before reset asserts never produces rvalid.
- Grant (combinational, same cycle):
  - State ARB:
    - grant1 = p1_valid & (~p0_valid | wait_cnt == MAX_WAIT).
    - grant0 = p0_valid & ~grant1.
  - State LOCKED1:
    - grant1 = p1_valid, grant0 = 0.
  - pX_ready = grantX.
  - mem_* are muxed from the granted port; mem_en = grant0 | grant1. With no grant, mem_* hold 0.
- Starvation counter:
  - wait_cnt width is $clog2(MAX_WAIT+1).
  - Increments (saturating at MAX_WAIT) on any cycle with p1_valid & ~p1_ready.
  - Clears on any cycle with p1_ready, and also when p1_valid is 0.
- FSM:
  - ARB -> LOCKED1 when grant1 & p1_lock.
  - LOCKED1 -> ARB at the first edge where p1_lock == 0. In that cycle grant logic still uses LOCKED1, so port 0 is not granted; port 0 may win from the following cycle.
  - p1_lock is ignored when port 1 is not granted in ARB.
- Read return:
  - An accepted read (ready & ~we) sets rd_owner to that port for the next cycle.
  - In that next cycle: pX_rvalid = 1 and pX_rdata = mem_rdata, both combinational from the memory output.
  - The non-owner's rvalid is 0 and its rdata is held at 0.
  - Back-to-back reads pipeline at 1 per cycle, latency exactly 1.
  - Writes produce no rvalid.
- Simultaneous events:
  - Both ports valid with wait_cnt < MAX_WAIT: port 0 wins.
  - Both ports valid with wait_cnt == MAX_WAIT: port 1 wins exactly once, then the counter clears.
  - Requests are not queued; an unaccepted requester must hold its valid and payload stable.

Decomposition:
- Shared package rv_mem_pkg holds:
  - typedef arb_state_t {ARB, LOCKED1}.
  - typedef owner_t {OWN_NONE, OWN_P0, OWN_P1}.
  - localparams for default widths.
- No sub-module is needed. The grant mux is small enough to stay inline.

Test Plan:
- Reset check: reset=0 for 2 cycles with p0_valid=1 -> ready0=0, mem_en=0, rvalid0=0. Release reset -> p0 is granted on the first cycle.
- Core-only traffic: port 0 stores 0xDEADBEEF to 0x10 with mask 4'hF, then loads 0x10 -> ready0=1 in both cycles; rvalid0=1 with rdata0=0xDEADBEEF exactly one cycle after the load.
- Starvation guard (MAX_WAIT=4): p0_valid and p1_valid held high continuously -> p1_ready=1 on the 5th cycle only; the pattern repeats every 5 cycles; p0_stall is high exactly during port 1's grants.
- Lock burst: port 1 is granted with p1_lock=1 and writes 0..7 to 0x100..0x11C while p0_valid=1 -> p0_stall stays high throughout. After p1_lock drops, port 0 is granted one cycle later. Port 0 then reads 0x104 -> returns 1.
- Read ownership: alternating reads p0@0x10 and p1@0x100 (with counter forcing) -> each rvalid pulses only on its owning port, data is correct, and there is no cross-delivery.
- Reset mid-read: port 0 read accepted, reset=0 on the next edge -> no rvalid0 is generated; state returns to ARB and wait_cnt returns to 0.
